// File: rtl/reg_write_queue.sv
// Buffered write queue feeding the register file's single write port, drained whenever writeback is idle.
// Optional decode forwarding of pending values is enabled by defining REG_WRITE_QUEUE_BYPASS_EN.
module reg_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_reg,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     wb_busy,
    output logic                     regWrite,
    output logic [ADDR_W-1:0]        writeReg,
    output logic [DATA_W-1:0]        writeData,
    input  logic [ADDR_W-1:0]        lk_reg,
    output logic                     lk_hit,
    output logic [DATA_W-1:0]        lk_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] entryReg  [DEPTH];
    logic [DATA_W-1:0] entryData [DEPTH];

    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [CNT_W-1:0] countReg;

    logic notEmpty;
    logic push;
    logic enq;
    logic pop;

    assign notEmpty = (countReg != '0);
    assign in_ready = (countReg != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    // Register 0 is hardwired, so its writes complete the handshake but are dropped.
    assign enq      = push && (in_reg != '0);
    assign pop      = notEmpty && !wb_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            countReg <= '0;
        end else begin
            if (enq) begin
                tailPtr <= tailPtr + 1'b1;
            end
            if (pop) begin
                headPtr <= headPtr + 1'b1;
            end
            case ({enq, pop})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            entryReg[tailPtr]  <= in_reg;
            entryData[tailPtr] <= in_data;
        end
    end

    assign regWrite  = pop;
    assign writeReg  = notEmpty ? entryReg[headPtr]  : '0;
    assign writeData = notEmpty ? entryData[headPtr] : '0;
    assign count     = countReg;

`ifdef REG_WRITE_QUEUE_BYPASS_EN
    logic [DEPTH-1:0] slotMatch;
    logic [PTR_W-1:0] scanIdx;
    logic             hitComb;
    logic [DATA_W-1:0] dataComb;

    // A slot is pending when its distance from the head is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gSlot
        logic [PTR_W-1:0] slotAge;
        assign slotAge       = PTR_W'(gi) - headPtr;
        assign slotMatch[gi] = ({1'b0, slotAge} < countReg) && (entryReg[gi] == lk_reg);
    end

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        hitComb  = 1'b0;
        dataComb = '0;
        scanIdx  = headPtr;
        for (int k = 0; k < DEPTH; k++) begin
            scanIdx = headPtr + PTR_W'(k);
            if (slotMatch[scanIdx] && (lk_reg != '0)) begin
                hitComb  = 1'b1;
                dataComb = entryData[scanIdx];
            end
        end
    end

    assign lk_hit  = hitComb;
    assign lk_data = dataComb;
`else
    logic unusedLk;
    assign unusedLk = ^lk_reg;
    assign lk_hit   = 1'b0;
    assign lk_data  = '0;
`endif

endmodule

// File: tb/tb_reg_write_queue.sv
// Self-checking bench for reg_write_queue: directed vector table, random traffic against a queue model, async reset.
module tb_reg_write_queue;

`ifdef REG_WRITE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        wb_busy;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  lk_reg;
    logic        lk_hit;
    logic [31:0] lk_data;
    logic [2:0]  count;

    reg_write_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .wb_busy(wb_busy),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .lk_reg(lk_reg), .lk_hit(lk_hit), .lk_data(lk_data),
        .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;
    ent_t modelQ[$];

    typedef struct {
        logic        v;
        logic [4:0]  r;
        logic [31:0] d;
        logic        busy;
        logic [4:0]  lk;
        logic [2:0]  eCnt;
        logic        eRdy;
        logic        eRw;
        logic [4:0]  eWr;
        logic [31:0] eWd;
        logic        eHit;
        logic [31:0] eLd;
    } vec_t;
    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs straight from the queue contents and the current inputs.
    task automatic checkModel(input string tag);
        logic        eHit;
        logic [31:0] eLd;
        eHit = 1'b0;
        eLd  = '0;
        if (BYP && lk_reg != 0) begin
            foreach (modelQ[i]) begin
                if (modelQ[i].r == lk_reg) begin
                    eHit = 1'b1;
                    eLd  = modelQ[i].d;
                end
            end
        end
        chk({tag, ".count"},     32'(count),     32'(modelQ.size()));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(modelQ.size() != DEPTH));
        chk({tag, ".regWrite"},  32'(regWrite),  32'(modelQ.size() != 0 && !wb_busy));
        chk({tag, ".writeReg"},  32'(writeReg),  (modelQ.size() != 0) ? 32'(modelQ[0].r) : 32'd0);
        chk({tag, ".writeData"}, writeData,      (modelQ.size() != 0) ? modelQ[0].d : 32'd0);
        chk({tag, ".lk_hit"},    32'(lk_hit),    32'(eHit));
        chk({tag, ".lk_data"},   lk_data,        eLd);
    endtask

    task automatic modelStep();
        bit doPop, doPush;
        doPop  = (modelQ.size() != 0) && !wb_busy;
        doPush = in_valid && (modelQ.size() != DEPTH);
        if (doPop || doPush)
            $display("txn t=%0t push=%0d r%0d=%h pop=%0d r%0d", $time, doPush, in_reg, in_data,
                     doPop, doPop ? modelQ[0].r : 5'd0);
        if (doPop) void'(modelQ.pop_front());
        if (doPush && in_reg != 0) modelQ.push_back('{r: in_reg, d: in_data});
    endtask

    task automatic modelCycle(input string tag);
        #3;
        checkModel(tag);
        modelStep();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 0; in_reg = 0; in_data = 0; wb_busy = 0; lk_reg = 0;

        tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 5, 0, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 5, 1, 1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF};
        tbl[2]  = '{0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 32'h101, 1, 1, 0, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 2, 32'h102, 1, 1, 1, 1, 0, 1, 32'h101, 1, 32'h101};
        tbl[5]  = '{1, 3, 32'h103, 1, 2, 2, 1, 0, 1, 32'h101, 1, 32'h102};
        tbl[6]  = '{1, 4, 32'h104, 1, 3, 3, 1, 0, 1, 32'h101, 1, 32'h103};
        tbl[7]  = '{1, 9, 32'h999, 1, 4, 4, 0, 0, 1, 32'h101, 1, 32'h104};
        tbl[8]  = '{1, 9, 32'h999, 0, 9, 4, 0, 1, 1, 32'h101, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 1, 3, 1, 1, 2, 32'h102, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 3, 2, 1, 1, 3, 32'h103, 1, 32'h103};
        tbl[11] = '{0, 0, 0, 0, 4, 1, 1, 1, 4, 32'h104, 1, 32'h104};
        tbl[12] = '{1, 7, 32'h11, 1, 7, 0, 1, 0, 0, 0, 0, 0};
        tbl[13] = '{1, 7, 32'h22, 1, 7, 1, 1, 0, 7, 32'h11, 1, 32'h11};
        tbl[14] = '{0, 0, 0, 1, 7, 2, 1, 0, 7, 32'h11, 1, 32'h22};
        tbl[15] = '{0, 0, 0, 0, 7, 2, 1, 1, 7, 32'h11, 1, 32'h22};
        tbl[16] = '{0, 0, 0, 0, 7, 1, 1, 1, 7, 32'h22, 1, 32'h22};
        tbl[17] = '{1, 0, 32'h1234, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[18] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle after reset.
        for (int c = 0; c < 10; c++) begin
            #3;
            $display("idle cycle %0d count=%0d regWrite=%0d", c, count, regWrite);
            chk("idle.count",     32'(count),    32'd0);
            chk("idle.in_ready",  32'(in_ready), 32'd1);
            chk("idle.regWrite",  32'(regWrite), 32'd0);
            chk("idle.writeReg",  32'(writeReg), 32'd0);
            chk("idle.writeData", writeData,     32'd0);
            @(posedge clk);
            #1;
        end

        // Directed vectors: outputs expected before the edge that applies each row.
        for (int i = 0; i < 19; i++) begin
            in_valid = tbl[i].v; in_reg = tbl[i].r; in_data = tbl[i].d;
            wb_busy = tbl[i].busy; lk_reg = tbl[i].lk;
            #3;
            $display("vec %0d v=%0d r%0d d=%h busy=%0d lk=%0d count=%0d rw=%0d wr=%0d wd=%h",
                     i, in_valid, in_reg, in_data, wb_busy, lk_reg, count, regWrite, writeReg, writeData);
            chk($sformatf("vec%0d.count", i),     32'(count),    32'(tbl[i].eCnt));
            chk($sformatf("vec%0d.in_ready", i),  32'(in_ready), 32'(tbl[i].eRdy));
            chk($sformatf("vec%0d.regWrite", i),  32'(regWrite), 32'(tbl[i].eRw));
            chk($sformatf("vec%0d.writeReg", i),  32'(writeReg), 32'(tbl[i].eWr));
            chk($sformatf("vec%0d.writeData", i), writeData,     tbl[i].eWd);
            chk($sformatf("vec%0d.lk_hit", i),    32'(lk_hit),   BYP ? 32'(tbl[i].eHit) : 32'd0);
            chk($sformatf("vec%0d.lk_data", i),   lk_data,       BYP ? tbl[i].eLd : 32'd0);
            @(posedge clk);
            #1;
        end

        // Random traffic against the queue model (queue is empty here).
        modelQ.delete();
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            in_reg   = 5'($urandom_range(0, 7));
            in_data  = $urandom;
            wb_busy  = ($urandom_range(0, 99) < 35);
            lk_reg   = 5'($urandom_range(0, 7));
            modelCycle("rnd");
        end

        // Drain, then fill three entries and reset mid-cycle.
        in_valid = 0; wb_busy = 0;
        for (int c = 0; c < DEPTH + 1; c++) modelCycle("drain");
        wb_busy = 1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1; in_reg = 5'(c + 10); in_data = 32'hA000 + 32'(c); lk_reg = 5'd11;
            modelCycle("fill");
        end
        in_valid = 0; wb_busy = 0; lk_reg = 5'd11;
        #1;
        checkModel("prerst");
        rst_n = 1'b0;
        #1;
        $display("reset asserted count=%0d regWrite=%0d", count, regWrite);
        chk("rst.count",     32'(count),    32'd0);
        chk("rst.in_ready",  32'(in_ready), 32'd1);
        chk("rst.regWrite",  32'(regWrite), 32'd0);
        chk("rst.writeReg",  32'(writeReg), 32'd0);
        chk("rst.writeData", writeData,     32'd0);
        chk("rst.lk_hit",    32'(lk_hit),   32'd0);
        chk("rst.lk_data",   lk_data,       32'd0);
        modelQ.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) modelCycle("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_queue.md
# reg_write_queue

Buffered write-side driver for the 32x32 register file's single write port. Producers that finish out of step with the main pipeline (multi-cycle load/divide units) push register writes here. The queue drains one entry per cycle into `regWrite`/`writeReg`/`writeData` whenever the main writeback stage is not using the port. A lookup port exposes pending values so decode can forward data that has not reached the register file yet.

## Interface
Parameters:
- `DEPTH`, 4: entry count; power of two, 2..16.
- `DATA_W`, 32: write data width.
- `ADDR_W`, 5: register index width.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  producer has a write to enqueue.
- `in_ready`  out  1  queue can accept; equals `count != DEPTH`.
- `in_reg`  in  ADDR_W  destination register index.
- `in_data`  in  DATA_W  destination value.
- `wb_busy`  in  1  main writeback owns the regfile port this cycle; inhibits drain.
- `regWrite`  out  1  write enable to regfile.
- `writeReg`  out  ADDR_W  write index to regfile.
- `writeData`  out  DATA_W  write data to regfile.
- `lk_reg`  in  ADDR_W  register index being read in decode.
- `lk_hit`  out  1  a pending entry targets `lk_reg`.
- `lk_data`  out  DATA_W  value of the youngest matching pending entry.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Storage: circular buffer of DEPTH {reg, data} entries with head (read) and tail (write) pointers of log2(DEPTH) bits that wrap modulo DEPTH. A separate occupancy counter distinguishes full from empty.
- Push: `in_valid && in_ready` at an edge writes {in_reg, in_data} at the tail, then increments the tail.
- Writes to register 0 are accepted (handshake completes) but are discarded and never enqueued.
- Pop: `pop = (count != 0) && !wb_busy`. The head entry is presented on the outputs during the cycle, and the head pointer advances at the edge. The regfile always accepts the write, so there is no back-pressure beyond `wb_busy`.
- Outputs are combinational from the head entry:
  - `regWrite = pop`.
  - When `count == 0`: `writeReg = 0` and `writeData = 0`.
  - When `count != 0`: `writeReg` and `writeData` show the head entry regardless of `wb_busy`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Push while full is impossible because `in_ready` is low. A push is not accepted in the same cycle that a full queue pops; `in_ready` uses the start-of-cycle count.
- Ordering: entries drain in strict FIFO order. Two pending writes to the same register reach the regfile oldest-first, so the younger value persists.
- Lookup (combinational; see Configuration):
  - `lk_hit` = any valid entry with reg == `lk_reg` and `lk_reg != 0`.
  - `lk_data` = data of the youngest such entry (nearest the tail).
  - When `lk_hit` is 0, `lk_data` = 0.
  - The head entry counts as pending during its pop cycle.
  - An entry being pushed in the current cycle is not visible until the next cycle.

## Timing
- Reset (`rst_n` low, asynchronous): `count` = 0, head = tail = 0, `in_ready` = 1, `regWrite` = 0, `writeReg` = 0, `writeData` = 0, `lk_hit` = 0, `lk_data` = 0. Entry storage need not be cleared.
- Reset asserted mid-operation discards all pending entries immediately; no partial write is issued after assertion.
- Latency: an entry pushed at edge N can first appear with `regWrite` = 1 in cycle N+1. With `wb_busy` held low, it reaches the regfile at edge N+1. There is no same-cycle pass-through.
- Throughput: one push and one pop per cycle sustained.
- `wb_busy` high holds the head stable; the entry pops in the first cycle `wb_busy` is low.

## Configuration
- `REG_WRITE_QUEUE_BYPASS_EN` defined: the lookup port is implemented as described.
- `REG_WRITE_QUEUE_BYPASS_EN` undefined: the comparators are removed, and `lk_hit` and `lk_data` are tied to 0. Ports remain so the instantiation is unchanged, and all queue behaviour is identical.

## Test plan
- Reset then idle: `count` = 0, `in_ready` = 1, `regWrite` = 0, `writeReg` = 0, `writeData` = 0 for 10 cycles.
- Push {r5, 0xDEADBEEF} with `wb_busy` = 0: next cycle `regWrite` = 1, `writeReg` = 5, `writeData` = 0xDEADBEEF; `count` returns to 0 after that edge.
- Hold `wb_busy` = 1 and push 4 entries r1..r4 (DEPTH = 4): `count` = 4 and `in_ready` = 0. A fifth `in_valid` is not accepted. Releasing `wb_busy` drains r1, r2, r3, r4 on four consecutive cycles, and pointers wrap correctly on a refill.
- Push r7 = 0x11 then r7 = 0x22 with `wb_busy` = 1, and set `lk_reg` = 7:
  - With `REG_WRITE_QUEUE_BYPASS_EN`: `lk_hit` = 1 and `lk_data` = 0x22. The drain order is 0x11 then 0x22.
  - Without the macro: `lk_hit` = 0 and `lk_data` = 0.
- Push {r0, 0x1234}: the handshake completes, `count` stays 0, and `regWrite` never asserts. Setting `lk_reg` = 0 gives `lk_hit` = 0.
- With 3 entries pending, pulse `rst_n` low mid-cycle: outputs go to reset values asynchronously, and no `regWrite` follows release.
